// File: rtl/dotp_host_sequencer.sv
// Purpose: AXI-Lite host front-end for the dot-product accelerator. It holds the
//          config registers and a pair FIFO, and runs the fetch/compute/write/read
//          command sequence into axi_slave.
// Latency: write response 1 cycle after the AW/W handshake, read data 1 cycle after
//          the AR handshake, and one start pulse per sequencer step.
// Backpressure: one write and one read outstanding at a time. B and R hold until the
//          host accepts them. Every slave step waits for its done flag, with a timeout.
// Ports:   clk/rst (sync, active-high); s_aw*/s_w*/s_b* host write channel;
//          s_ar*/s_r* host read channel; wdata_*/waddr_*/waddr_output/vector_len_o
//          carry operands and addresses to axi_slave; start_* are the command pulses;
//          *_done, read_data and status come back from axi_slave.
module dotp_host_sequencer #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [7:0]  s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] wdata_a,
    output logic [31:0] wdata_b,
    output logic [31:0] waddr_a,
    output logic [31:0] waddr_b,
    output logic [31:0] waddr_output,
    output logic [31:0] vector_len_o,
    output logic        wdvalid,
    output logic        awvalid,
    output logic        start_fetch,
    output logic        start_compute,
    output logic        start_write,
    output logic        start_read,
    input  logic [31:0] read_data,
    input  logic        status,
    input  logic        fetch_done,
    input  logic        processing_done,
    input  logic        store_done,
    input  logic        read_done
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [7:0] A_CTRL     = 8'h00;
    localparam logic [7:0] A_STATUS   = 8'h04;
    localparam logic [7:0] A_LEN      = 8'h08;
    localparam logic [7:0] A_ADDR_A   = 8'h0C;
    localparam logic [7:0] A_ADDR_B   = 8'h10;
    localparam logic [7:0] A_ADDR_OUT = 8'h14;
    localparam logic [7:0] A_ELEM_A   = 8'h18;
    localparam logic [7:0] A_ELEM_B   = 8'h1C;
    localparam logic [7:0] A_RESULT   = 8'h20;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH_ISSUE, S_FETCH_WAIT, S_COMP, S_COMP_WAIT,
        S_WR, S_WR_WAIT, S_RD, S_RD_WAIT, S_DONE
    } state_t;

    state_t r_state, w_next;

    // Configuration and status registers.
    logic [31:0] r_len, r_addr_a, r_addr_b, r_addr_out, r_pend_a, r_result;
    logic        r_done, r_error;
    logic [31:0] r_idx;
    logic [31:0] r_wdata_a, r_wdata_b;
    logic [TW-1:0] r_wait_cnt;

    // Pair FIFO.
    logic [31:0]   r_fifo_a [DEPTH];
    logic [31:0]   r_fifo_b [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;

    // Host channel state.
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_rvalid;
    logic [31:0] r_rdata;

    logic        w_wr_hs, w_rd_hs, w_busy, w_full;
    logic        w_is_ctrl, w_clear, w_start_req, w_len_ok;
    logic        w_start_ok, w_start_fail, w_start_busy_err;
    logic        w_cfg_addr, w_cfg_busy_err, w_push, w_push_full_err, w_slverr;
    logic        w_pop, w_timeout, w_capture, w_fetch_ack;
    logic        w_wait_state, w_wait_expired, w_fetch_win;
    logic [31:0] w_rd_mux;

    // ---------------- host decode ----------------
    assign w_busy  = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_wr_hs = s_awvalid && s_wvalid && !r_bvalid && !rst;
    assign w_rd_hs = s_arvalid && !r_rvalid && !rst;

    assign w_is_ctrl   = w_wr_hs && (s_awaddr == A_CTRL);
    // CLEAR wins over START when both bits are set in one write.
    assign w_clear     = w_is_ctrl && s_wdata[1];
    assign w_start_req = w_is_ctrl && s_wdata[0] && !s_wdata[1];
    assign w_len_ok    = (r_len != 32'd0) && (r_len <= 32'(DEPTH)) &&
                         (32'(r_count) >= r_len);
    assign w_start_ok       = w_start_req && !w_busy && w_len_ok;
    assign w_start_fail     = w_start_req && !w_busy && !w_len_ok;
    assign w_start_busy_err = w_start_req && w_busy;

    assign w_cfg_addr = (s_awaddr == A_LEN)    || (s_awaddr == A_ADDR_A) ||
                        (s_awaddr == A_ADDR_B) || (s_awaddr == A_ADDR_OUT) ||
                        (s_awaddr == A_ELEM_A) || (s_awaddr == A_ELEM_B);
    assign w_cfg_busy_err  = w_wr_hs && w_cfg_addr && w_busy;
    assign w_push          = w_wr_hs && (s_awaddr == A_ELEM_B) && !w_busy && !w_full;
    assign w_push_full_err = w_wr_hs && (s_awaddr == A_ELEM_B) && !w_busy && w_full;
    assign w_slverr        = w_cfg_busy_err || w_push_full_err || w_start_busy_err;

    always_comb begin
        w_rd_mux = 32'd0;
        case (s_araddr)
            A_STATUS:   w_rd_mux = {16'd0, 8'(r_count), 4'd0, status, r_error, r_done, w_busy};
            A_LEN:      w_rd_mux = r_len;
            A_ADDR_A:   w_rd_mux = r_addr_a;
            A_ADDR_B:   w_rd_mux = r_addr_b;
            A_ADDR_OUT: w_rd_mux = r_addr_out;
            A_RESULT:   w_rd_mux = r_result;
            default:    w_rd_mux = 32'd0;
        endcase
    end

    // ---------------- sequencer FSM ----------------
    assign w_wait_state = (r_state == S_FETCH_WAIT) || (r_state == S_COMP_WAIT) ||
                          (r_state == S_WR_WAIT)    || (r_state == S_RD_WAIT);
    assign w_wait_expired = (r_wait_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        w_next      = r_state;
        w_pop       = 1'b0;
        w_timeout   = 1'b0;
        w_capture   = 1'b0;
        w_fetch_ack = 1'b0;
        case (r_state)
            S_IDLE: if (w_start_ok) w_next = S_FETCH_ISSUE;
            S_FETCH_ISSUE: begin
                w_pop  = 1'b1;
                w_next = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                if (fetch_done) begin
                    w_fetch_ack = 1'b1;
                    w_next = ((r_idx + 32'd1) == r_len) ? S_COMP : S_FETCH_ISSUE;
                end else if (w_wait_expired) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_COMP: w_next = S_COMP_WAIT;
            S_COMP_WAIT: begin
                if (processing_done) w_next = S_WR;
                else if (w_wait_expired) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_WR: w_next = S_WR_WAIT;
            S_WR_WAIT: begin
                if (store_done) w_next = S_RD;
                else if (w_wait_expired) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_RD: w_next = S_RD_WAIT;
            S_RD_WAIT: begin
                if (read_done) begin
                    w_capture = 1'b1;
                    w_next    = S_DONE;
                end else if (w_wait_expired) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            // A new START is already legal here because busy is low.
            S_DONE: w_next = w_start_ok ? S_FETCH_ISSUE : S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // Abort overrides everything. The flush below makes the pop irrelevant.
        if (w_clear) begin
            w_next      = S_IDLE;
            w_pop       = 1'b0;
            w_timeout   = 1'b0;
            w_capture   = 1'b0;
            w_fetch_ack = 1'b0;
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_addr_a   <= '0;
            r_addr_b   <= '0;
            r_addr_out <= '0;
            r_pend_a   <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_idx      <= '0;
            r_wdata_a  <= '0;
            r_wdata_b  <= '0;
            r_wait_cnt <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next;

            if (w_wr_hs) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_slverr ? 2'b10 : 2'b00;
            end else if (r_bvalid && s_bready) begin
                r_bvalid <= 1'b0;
            end

            if (w_rd_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_mux;
            end else if (r_rvalid && s_rready) begin
                r_rvalid <= 1'b0;
            end

            if (w_wr_hs && !w_busy) begin
                case (s_awaddr)
                    A_LEN:      r_len      <= s_wdata;
                    A_ADDR_A:   r_addr_a   <= s_wdata;
                    A_ADDR_B:   r_addr_b   <= s_wdata;
                    A_ADDR_OUT: r_addr_out <= s_wdata;
                    A_ELEM_A:   r_pend_a   <= s_wdata;
                    default: ;
                endcase
            end
            if (w_clear) r_pend_a <= '0;

            if (w_clear || w_start_ok) begin
                r_done  <= 1'b0;
                r_error <= 1'b0;
            end else begin
                if (w_start_fail || w_timeout) r_error <= 1'b1;
                if (w_capture) r_done <= 1'b1;
            end

            if (w_start_ok) r_idx <= '0;
            else if (w_fetch_ack) r_idx <= r_idx + 32'd1;

            // Keep the popped pair on the bus for the whole FETCH_WAIT window.
            if (w_pop) begin
                r_wdata_a <= r_fifo_a[r_rptr];
                r_wdata_b <= r_fifo_b[r_rptr];
            end

            if (w_capture) r_result <= read_data;

            // Wait counter restarts on every entry into a wait state.
            if (w_wait_state && (w_next == r_state)) r_wait_cnt <= r_wait_cnt + 1'b1;
            else r_wait_cnt <= '0;

            if (w_clear) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // FIFO storage needs no reset. Its contents are only read behind the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_a[r_wptr] <= r_pend_a;
            r_fifo_b[r_wptr] <= s_wdata;
        end
    end

    // ---------------- outputs ----------------
    assign s_awready = w_wr_hs;
    assign s_wready  = w_wr_hs;
    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;
    assign s_arready = !r_rvalid && !rst;
    assign s_rvalid  = r_rvalid;
    assign s_rdata   = r_rdata;
    assign s_rresp   = 2'b00;

    assign w_fetch_win   = (r_state == S_FETCH_ISSUE) || (r_state == S_FETCH_WAIT);
    assign wdvalid       = w_fetch_win;
    assign awvalid       = w_fetch_win;
    assign start_fetch   = (r_state == S_FETCH_ISSUE);
    assign start_compute = (r_state == S_COMP);
    assign start_write   = (r_state == S_WR);
    assign start_read    = (r_state == S_RD);

    // In FETCH_ISSUE the head is shown directly, and from then on the latched copy.
    assign wdata_a = (r_state == S_FETCH_ISSUE) ? r_fifo_a[r_rptr] :
                     (r_state == S_FETCH_WAIT)  ? r_wdata_a : 32'd0;
    assign wdata_b = (r_state == S_FETCH_ISSUE) ? r_fifo_b[r_rptr] :
                     (r_state == S_FETCH_WAIT)  ? r_wdata_b : 32'd0;
    assign waddr_a = w_fetch_win ? (r_addr_a + r_idx) : 32'd0;
    assign waddr_b = w_fetch_win ? (r_addr_b + r_idx) : 32'd0;
    assign waddr_output = r_addr_out;
    assign vector_len_o = r_len;

endmodule

// File: doc/dotp_host_sequencer.md
Name: dotp_host_sequencer

Overview:
Host-facing AXI-Lite control front-end for the dot-product accelerator; sits directly upstream of axi_slave.
Buffers host-written element pairs (A,B) in a small pair FIFO and programs base addresses and vector length.
On host start, drives the axi_slave command interface: one start_fetch per element, then start_compute, start_write and start_read, each gated by the matching done flag.
Captures read_data into a host-readable RESULT register.

Parameters:
DEPTH, 16, pair-FIFO depth in element pairs (power of 2); also the maximum LEN.
TIMEOUT, 1024, max cycles waited for any done flag before the sequence errors out.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
s_awaddr  in  8  host write address (byte)
s_awvalid  in  1  host write-address valid
s_awready  out  1  write-address ready
s_wdata  in  32  host write data
s_wvalid  in  1  host write-data valid
s_wready  out  1  write-data ready
s_bresp  out  2  00 OKAY, 10 SLVERR
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  8  host read address
s_arvalid  in  1  read-address valid
s_arready  out  1  read-address ready
s_rdata  out  32  read data
s_rresp  out  2  always 00
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
wdata_a  out  32  element A to axi_slave
wdata_b  out  32  element B to axi_slave
waddr_a  out  32  ADDR_A + element index
waddr_b  out  32  ADDR_B + element index
waddr_output  out  32  ADDR_OUT register value
vector_len_o  out  32  LEN register value
wdvalid  out  1  high while wdata_a/b are valid (FETCH_ISSUE through FETCH_WAIT)
awvalid  out  1  high while waddr_a/b are valid (same window as wdvalid)
start_fetch  out  1  one-cycle pulse per element
start_compute  out  1  one-cycle pulse
start_write  out  1  one-cycle pulse
start_read  out  1  one-cycle pulse
read_data  in  32  result from axi_slave
status  in  1  slave status; mirrored into STATUS bit 3
fetch_done  in  1  element fetch complete
processing_done  in  1  compute complete
store_done  in  1  store complete
read_done  in  1  read complete; read_data valid in the same cycle

Behaviour:
- Reset: every output 0 (s_* ready/valid signals, all command outputs, all address/data outputs). Registers, FIFO pointers and FSM cleared; state IDLE.
- Register map:
  - 0x00 CTRL (W): bit0 START, bit1 CLEAR; self-clearing.
  - 0x04 STATUS (R): bit0 busy, bit1 done, bit2 error, bit3 status, bits[15:8] FIFO count.
  - 0x08 LEN (RW).
  - 0x0C ADDR_A (RW).
  - 0x10 ADDR_B (RW).
  - 0x14 ADDR_OUT (RW).
  - 0x18 ELEM_A (W): latches pending A.
  - 0x1C ELEM_B (W): pushes {pending A, wdata} as one pair.
  - 0x20 RESULT (R).
  - Unmapped reads return 0 with OKAY. Unmapped writes are ignored and return OKAY.
- AXI write handshake:
  - s_awready and s_wready both assert for one cycle only when s_awvalid and s_wvalid are both high and s_bvalid is low.
  - s_bvalid rises the next cycle and holds until s_bready.
  - One write outstanding at a time.
- AXI read handshake:
  - s_arready is high when s_rvalid is low.
  - s_rdata is registered; s_rvalid rises 1 cycle after the address handshake and holds until s_rready.
- SLVERR cases (register state unchanged in each):
  - ELEM_B write with FIFO full: no push.
  - LEN, ADDR_*, ELEM_* writes while busy.
  - START while busy: ignored.
- START checks: if LEN == 0, LEN > DEPTH, or FIFO count < LEN, the write is accepted OKAY, error = 1, and the FSM stays IDLE. Otherwise done and error clear, busy sets, and the element index resets to 0.
- FSM states: IDLE, FETCH_ISSUE, FETCH_WAIT, COMP, COMP_WAIT, WR, WR_WAIT, RD, RD_WAIT, DONE.
  - FETCH_ISSUE: pop the FIFO head onto wdata_a/b; drive waddr_a/b = base + index; pulse start_fetch for 1 cycle; go to FETCH_WAIT.
  - FETCH_WAIT: on fetch_done, index++. If index == LEN go to COMP, else go to FETCH_ISSUE.
  - COMP: pulse start_compute, go to COMP_WAIT; processing_done -> WR.
  - WR: pulse start_write, go to WR_WAIT; store_done -> RD.
  - RD: pulse start_read, go to RD_WAIT; read_done -> capture read_data into RESULT, go to DONE.
  - DONE: done = 1, busy = 0, go to IDLE next cycle.
- A done flag asserted in the same cycle as the start pulse is ignored. Only flags seen in *_WAIT states count.
- Timeout: a wait counter resets on entry to each *_WAIT state. If it reaches TIMEOUT, set error = 1, busy = 0, go to IDLE, and do not flush the FIFO.
- CLEAR (any state, highest priority over START in the same write):
  - Abort the sequence, flush the FIFO, clear done, error and pending A; go to IDLE next cycle.
  - No start pulses issue after the CLEAR cycle.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - A simultaneous push (host) and pop (FETCH_ISSUE) in the same cycle keeps the count unchanged. This only arises if a host push while busy were allowed; pushes while busy get SLVERR, so it cannot occur.
  - Popped entries are consumed; leftover pairs beyond LEN remain for the next START.
- Arithmetic: waddr additions are 32-bit modulo; element data passes through unmodified (signed two's complement).

Test Plan:
- Reset with rst high for 2 cycles -> all outputs 0, STATUS reads 0x00000000.
- Write ADDR_A=0, ADDR_B=0, ADDR_OUT=15, LEN=4; push pairs (11,-4), (-5,12), (7,-10), (-5,10); START; slave model returns fetch_done 3 cycles after each start_fetch, and read_data=-224 with read_done -> exactly 4 start_fetch pulses with waddr_a = 0,1,2,3 and wdata_a/b matching, then one pulse each of compute, write and read in order; RESULT = 0xFFFFFF20; STATUS done=1, busy=0.
- LEN=5 with only 4 pairs queued, then START -> error=1, no start_fetch pulse, FIFO count still 4.
- Push 17 pairs with DEPTH=16 -> 17th ELEM_B gets bresp=10; count reads 16.
- Slave model never asserts processing_done -> after TIMEOUT cycles error=1, busy=0, no start_write pulse.
- CLEAR during FETCH_WAIT of element 2 -> FSM IDLE next cycle, FIFO count 0, no further start_* pulses; a new LEN=1 run then completes normally.
